// File: rtl/botoes_pkg.sv
// Shared constants for the button-matrix scanner and the LED matrix driver.
// Holds default scan geometry, the key-index mapping and named puzzle buttons.
package botoes_pkg;

    localparam int unsigned N_COLS_DEF         = 2;
    localparam int unsigned N_ROWS_DEF         = 3;
    localparam int unsigned SCAN_DIV_DEF       = 1000;
    localparam int unsigned DEBOUNCE_SCANS_DEF = 4;

    // Puzzle buttons by flat key index, as consumed by the LED matrix driver
    localparam int unsigned BTN_CIMA     = 0;
    localparam int unsigned BTN_BAIXO    = 1;
    localparam int unsigned BTN_ESQUERDA = 2;
    localparam int unsigned BTN_DIREITA  = 3;
    localparam int unsigned BTN_CONFIRMA = 4;
    localparam int unsigned BTN_REINICIA = 5;

    function automatic int unsigned indice_tecla(input int unsigned col,
                                                 input int unsigned row,
                                                 input int unsigned n_rows);
        return col * n_rows + row;
    endfunction

endpackage

// File: rtl/debounce_tecla.sv
// Per-key debouncer: counts consecutive scan samples that disagree with the
// debounced level and flips it after DEBOUNCE_SCANS of them; pulses on press.
module debounce_tecla #(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    input  logic habilitado,
    output logic estado,
    output logic pulso
);

    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          estado_q, estado_d;
    logic          pulso_q, pulso_d;

    always_comb begin
        cnt_d    = cnt_q;
        estado_d = estado_q;
        pulso_d  = 1'b0;
        if (habilitado && tick) begin
            if (raw == estado_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
                cnt_d    = '0;
                estado_d = raw;
                pulso_d  = raw;  // only presses pulse, releases are silent
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            estado_q <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
            pulso_q  <= pulso_d;
        end
    end

    assign estado = estado_q;
    assign pulso  = pulso_q;

endmodule

// File: rtl/leitor_botoes_matriz.sv
// Button-matrix scanner: drives one active-low column per slot, synchronizes
// the active-low row senses and debounces every key into press pulses.
module leitor_botoes_matriz
    import botoes_pkg::*;
#(
    parameter int unsigned N_COLS         = N_COLS_DEF,
    parameter int unsigned N_ROWS         = N_ROWS_DEF,
    parameter int unsigned SCAN_DIV       = SCAN_DIV_DEF,
    parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       habilitado,
    input  logic [N_ROWS-1:0]          sense,
    output logic [N_COLS-1:0]          colunas_varredura,
    output logic [N_COLS*N_ROWS-1:0]   botoes,
    output logic [N_COLS*N_ROWS-1:0]   estado
);

    localparam int unsigned PW  = $clog2(SCAN_DIV);
    localparam int unsigned CLW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [CLW-1:0]    col_q, col_d;
    logic [N_ROWS-1:0] sync1_q, sync2_q;
    logic              tick;
    logic [N_COLS-1:0] tick_col;

    assign tick = habilitado && (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d = presc_q;
        col_d   = col_q;
        if (habilitado) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            col_d = (col_q == CLW'(N_COLS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            col_q   <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            presc_q <= presc_d;
            col_q   <= col_d;
            sync1_q <= sense;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        colunas_varredura = '1;
        tick_col          = '0;
        if (habilitado) begin
            colunas_varredura[col_q] = 1'b0;
        end
        for (int c = 0; c < N_COLS; c++) begin
            tick_col[c] = tick && (col_q == CLW'(c));
        end
    end

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            localparam int unsigned K = indice_tecla(c, r, N_ROWS);

            debounce_tecla #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_tecla (
                .clk        (clk),
                .rst        (rst),
                .tick       (tick_col[c]),
                .raw        (~sync2_q[r]),
                .habilitado (habilitado),
                .estado     (estado[K]),
                .pulso      (botoes[K])
            );
        end
    end

endmodule
